pingpong_frame_buffer: RTL and testbench

Parametrised double-buffered (ping-pong) frame store for beatmap/VGA data paths. It holds two internal RAM banks of DEPTH words each. A producer fills the back bank through a valid/ready handshake while a consumer streams the front bank. The banks swap automatically at frame boundaries, so the consumer never reads a partially written frame.

---
 rtl/pingpong_frame_buffer.sv | 116 +++++++++++
 tb/tb_pingpong_frame_buffer.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/pingpong_frame_buffer.sv
// Two-bank frame store: producer fills the back bank, consumer streams the front bank, swap at frame boundaries.
// Read data 1 cycle after rd_en; wr_ready drops while the back bank holds a full frame not yet swapped in.
module pingpong_frame_buffer #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 32,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter int REPEAT = 1,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              wr_valid,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  input  logic              rd_en,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_last,
  output logic              front_sel,
  output logic [CNT_W-1:0]  frame_cnt,
  output logic              underrun
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  logic [DATA_W-1:0] r_bank0 [DEPTH];
  logic [DATA_W-1:0] r_bank1 [DEPTH];

  logic [ADDR_W-1:0] r_wr_addr;
  logic [ADDR_W-1:0] r_rd_addr;
  logic              r_back_full;
  logic              r_front_valid;
  logic              r_front_sel;
  logic [CNT_W-1:0]  r_frame_cnt;
  logic              r_rd_valid;
  logic [DATA_W-1:0] r_rd_data;
  logic              r_rd_last;
  logic              r_underrun;

  logic              w_wr_acc;
  logic              w_wr_last;
  logic              w_full_n;
  logic              w_rd_acc;
  logic              w_rd_end;
  logic              w_swap;
  logic [DATA_W-1:0] w_rd_word;

  assign wr_ready  = resetn & ~r_back_full;
  assign w_wr_acc  = wr_valid & wr_ready;
  assign w_wr_last = w_wr_acc & (r_wr_addr == LAST_ADDR);
  assign w_full_n  = r_back_full | w_wr_last;
  assign w_rd_acc  = rd_en & r_front_valid;
  assign w_rd_end  = w_rd_acc & (r_rd_addr == LAST_ADDR);
  // A frame completing this very edge may swap in immediately, so the reader sees no gap.
  assign w_swap    = w_full_n & (~r_front_valid | w_rd_end);
  assign w_rd_word = r_front_sel ? r_bank1[r_rd_addr] : r_bank0[r_rd_addr];

  always_ff @(posedge clk) begin
    if (w_wr_acc) begin
      if (r_front_sel) r_bank0[r_wr_addr] <= wr_data;
      else             r_bank1[r_wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_wr_addr     <= '0;
      r_rd_addr     <= '0;
      r_back_full   <= 1'b0;
      r_front_valid <= 1'b0;
      r_front_sel   <= 1'b0;
      r_frame_cnt   <= '0;
      r_rd_valid    <= 1'b0;
      r_rd_data     <= '0;
      r_rd_last     <= 1'b0;
      r_underrun    <= 1'b0;
    end else begin
      if (w_wr_acc)
        r_wr_addr <= (r_wr_addr == LAST_ADDR) ? '0 : r_wr_addr + ADDR_W'(1);

      if (w_swap)
        r_back_full <= 1'b0;
      else if (w_wr_last)
        r_back_full <= 1'b1;

      if (w_swap)
        r_front_valid <= 1'b1;
      else if (w_rd_end && REPEAT == 0)
        r_front_valid <= 1'b0;

      if (w_swap)
        r_rd_addr <= '0;
      else if (w_rd_acc)
        r_rd_addr <= (r_rd_addr == LAST_ADDR) ? '0 : r_rd_addr + ADDR_W'(1);

      if (w_swap) begin
        r_front_sel <= ~r_front_sel;
        r_frame_cnt <= r_frame_cnt + CNT_W'(1);
      end

      r_rd_valid <= w_rd_acc;
      r_rd_last  <= w_rd_end;
      r_underrun <= rd_en & ~r_front_valid;
      if (w_rd_acc)
        r_rd_data <= w_rd_word;
    end
  end

  assign rd_valid  = r_rd_valid;
  assign rd_data   = r_rd_data;
  assign rd_last   = r_rd_last;
  assign front_sel = r_front_sel;
  assign frame_cnt = r_frame_cnt;
  assign underrun  = r_underrun;

endmodule

// File: tb/tb_pingpong_frame_buffer.sv
// Directed bench: a vector table for fill/read/replay, then hand sequences for backpressure, simultaneous swap, REPEAT=0 and mid-frame reset.
module tb_pingpong_frame_buffer;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       wr_valid = 1'b0;
  logic [7:0] wr_data = '0;
  logic       rd_en = 1'b0;

  logic       wr_ready1, rd_valid1, rd_last1, front_sel1, underrun1;
  logic [7:0] rd_data1;
  logic [15:0] frame_cnt1;
  logic       wr_ready0, rd_valid0, rd_last0, front_sel0, underrun0;
  logic [7:0] rd_data0;
  logic [15:0] frame_cnt0;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  pingpong_frame_buffer #(.DATA_W(8), .DEPTH(32), .REPEAT(1), .CNT_W(16)) u_rep1 (
    .clk(clk), .resetn(resetn), .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready1),
    .rd_en(rd_en), .rd_valid(rd_valid1), .rd_data(rd_data1), .rd_last(rd_last1),
    .front_sel(front_sel1), .frame_cnt(frame_cnt1), .underrun(underrun1)
  );

  pingpong_frame_buffer #(.DATA_W(8), .DEPTH(32), .REPEAT(0), .CNT_W(16)) u_rep0 (
    .clk(clk), .resetn(resetn), .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready0),
    .rd_en(rd_en), .rd_valid(rd_valid0), .rd_data(rd_data0), .rd_last(rd_last0),
    .front_sel(front_sel0), .frame_cnt(frame_cnt0), .underrun(underrun0)
  );

  typedef struct {
    logic        rst_n;
    logic        wv;
    logic [7:0]  wd;
    logic        re;
    logic        e_wrdy;
    logic        e_rv;
    logic [7:0]  e_rd;
    logic        e_last;
    logic        e_fsel;
    logic [15:0] e_cnt;
    logic        e_und;
    logic        e_rv0;
    logic        e_und0;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic rst_n, input logic wv, input logic [7:0] wd, input logic re,
                              input logic e_wrdy, input logic e_rv, input logic [7:0] e_rd,
                              input logic e_last, input logic e_fsel, input logic [15:0] e_cnt,
                              input logic e_und, input logic e_rv0, input logic e_und0);
    vec_t v;
    v.rst_n = rst_n; v.wv = wv; v.wd = wd; v.re = re;
    v.e_wrdy = e_wrdy; v.e_rv = e_rv; v.e_rd = e_rd; v.e_last = e_last;
    v.e_fsel = e_fsel; v.e_cnt = e_cnt; v.e_und = e_und; v.e_rv0 = e_rv0; v.e_und0 = e_und0;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cyc(input logic wv, input logic [7:0] wd, input logic re);
    wr_valid = wv;
    wr_data  = wd;
    rd_en    = re;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    resetn   = 1'b0;
    wr_valid = 1'b0;
    rd_en    = 1'b0;
    @(posedge clk);
    #1;
    resetn = 1'b1;
  endtask

  initial begin
    // Reset, underrun on empty, fill, one read pass, then replay (REPEAT=1) vs underrun (REPEAT=0).
    tbl.push_back(mk(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk(1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 16'd0, 1'b1, 1'b0, 1'b1));
    for (int i = 0; i < 32; i++)
      tbl.push_back(mk(1'b1, 1'b1, 8'(i), 1'b0, 1'b1, 1'b0, 8'h00, 1'b0,
                       (i == 31), (i == 31) ? 16'd1 : 16'd0, 1'b0, 1'b0, 1'b0));
    for (int j = 0; j < 32; j++)
      tbl.push_back(mk(1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'(j), (j == 31),
                       1'b1, 16'd1, 1'b0, 1'b1, 1'b0));
    for (int k = 0; k < 4; k++)
      tbl.push_back(mk(1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'(k), 1'b0,
                       1'b1, 16'd1, 1'b0, 1'b0, 1'b1));
    tbl.push_back(mk(1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h03, 1'b0, 1'b1, 16'd1, 1'b0, 1'b0, 1'b0));

    #1;
    for (int n = 0; n < tbl.size(); n++) begin
      resetn   = tbl[n].rst_n;
      wr_valid = tbl[n].wv;
      wr_data  = tbl[n].wd;
      rd_en    = tbl[n].re;
      @(posedge clk);
      #1;
      chk($sformatf("v%0d.wr_ready", n),  wr_ready1,  tbl[n].e_wrdy);
      chk($sformatf("v%0d.rd_valid", n),  rd_valid1,  tbl[n].e_rv);
      chk($sformatf("v%0d.rd_data", n),   rd_data1,   tbl[n].e_rd);
      chk($sformatf("v%0d.rd_last", n),   rd_last1,   tbl[n].e_last);
      chk($sformatf("v%0d.front_sel", n), front_sel1, tbl[n].e_fsel);
      chk($sformatf("v%0d.frame_cnt", n), frame_cnt1, tbl[n].e_cnt);
      chk($sformatf("v%0d.underrun", n),  underrun1,  tbl[n].e_und);
      chk($sformatf("v%0d.rd_valid_r0", n), rd_valid0, tbl[n].e_rv0);
      chk($sformatf("v%0d.underrun_r0", n), underrun0, tbl[n].e_und0);
    end

    // REPEAT=0: reader keeps underrunning until the next frame completes and swaps in.
    for (int i = 0; i < 32; i++) begin
      cyc(1'b1, 8'(8'h40 + i), 1'b1);
      chk($sformatf("r0_wait%0d.underrun", i), underrun0, 1'b1);
      chk($sformatf("r0_wait%0d.rd_valid", i), rd_valid0, 1'b0);
    end
    cyc(1'b0, 8'h00, 1'b1);
    chk("r0_resume.rd_valid",  rd_valid0,  1'b1);
    chk("r0_resume.rd_data",   rd_data0,   8'h40);
    chk("r0_resume.underrun",  underrun0,  1'b0);
    chk("r0_resume.frame_cnt", frame_cnt0, 16'd2);
    chk("r0_resume.front_sel", front_sel0, 1'b0);
    chk("r0_resume.wr_ready",  wr_ready0,  1'b1);
    chk("r0_resume.rd_last",   rd_last0,   1'b0);

    // Backpressure: B fills behind A and stalls the writer until A's pass ends.
    do_reset();
    for (int i = 0; i < 32; i++) cyc(1'b1, 8'(8'h10 + i), 1'b0);
    chk("bp_fillA.frame_cnt", frame_cnt1, 16'd1);
    for (int i = 0; i < 32; i++) cyc(1'b1, 8'(8'h80 + i), 1'b0);
    chk("bp_fillB.wr_ready",  wr_ready1,  1'b0);
    chk("bp_fillB.frame_cnt", frame_cnt1, 16'd1);
    chk("bp_fillB.front_sel", front_sel1, 1'b1);
    for (int j = 0; j < 64; j++) begin
      cyc((j < 32), 8'hEE, 1'b1);
      chk($sformatf("bp_rd%0d.rd_valid", j), rd_valid1, 1'b1);
      chk($sformatf("bp_rd%0d.rd_data", j), rd_data1, (j < 32) ? 8'(8'h10 + j) : 8'(8'h80 + j - 32));
      if (j < 31) chk($sformatf("bp_rd%0d.wr_ready", j), wr_ready1, 1'b0);
      if (j == 31) begin
        chk("bp_swap.wr_ready",  wr_ready1,  1'b1);
        chk("bp_swap.frame_cnt", frame_cnt1, 16'd2);
        chk("bp_swap.front_sel", front_sel1, 1'b0);
      end
    end
    chk("bp_end.frame_cnt", frame_cnt1, 16'd2);

    // Last write of B and last read of A on the same edge.
    do_reset();
    for (int i = 0; i < 32; i++) cyc(1'b1, 8'(8'h20 + i), 1'b0);
    for (int i = 0; i < 32; i++) begin
      cyc(1'b1, 8'(8'h60 + i), 1'b1);
      chk($sformatf("sim_rd%0d.rd_data", i), rd_data1, 8'(8'h20 + i));
    end
    chk("sim_swap.frame_cnt", frame_cnt1, 16'd2);
    chk("sim_swap.front_sel", front_sel1, 1'b0);
    chk("sim_swap.wr_ready",  wr_ready1,  1'b1);
    chk("sim_swap.rd_last",   rd_last1,   1'b1);
    cyc(1'b0, 8'h00, 1'b1);
    chk("sim_next.rd_valid", rd_valid1, 1'b1);
    chk("sim_next.rd_data",  rd_data1,  8'h60);
    chk("sim_next.underrun", underrun1, 1'b0);

    // Reset mid-frame at wr_addr=17, rd_addr=9.
    do_reset();
    for (int i = 0; i < 32; i++) cyc(1'b1, 8'(8'h30 + i), 1'b0);
    for (int i = 0; i < 17; i++) cyc(1'b1, 8'(8'hA0 + i), (i < 9));
    chk("mid_pre.rd_data", rd_data1, 8'h38);
    resetn   = 1'b0;
    wr_valid = 1'b1;
    rd_en    = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_rst.wr_ready",  wr_ready1,  1'b0);
    chk("mid_rst.rd_valid",  rd_valid1,  1'b0);
    chk("mid_rst.rd_data",   rd_data1,   8'h00);
    chk("mid_rst.rd_last",   rd_last1,   1'b0);
    chk("mid_rst.front_sel", front_sel1, 1'b0);
    chk("mid_rst.frame_cnt", frame_cnt1, 16'd0);
    chk("mid_rst.underrun",  underrun1,  1'b0);
    resetn = 1'b1;
    cyc(1'b0, 8'h00, 1'b1);
    chk("mid_und.underrun", underrun1, 1'b1);
    chk("mid_und.rd_valid", rd_valid1, 1'b0);
    chk("mid_und.wr_ready", wr_ready1, 1'b1);
    for (int i = 0; i < 32; i++) cyc(1'b1, 8'(8'hC0 + i), 1'b0);
    chk("mid_fill.frame_cnt", frame_cnt1, 16'd1);
    chk("mid_fill.front_sel", front_sel1, 1'b1);
    for (int j = 0; j < 32; j++) begin
      cyc(1'b0, 8'h00, 1'b1);
      chk($sformatf("mid_rd%0d.rd_data", j), rd_data1, 8'(8'hC0 + j));
      chk($sformatf("mid_rd%0d.rd_last", j), rd_last1, (j == 31));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
